spike_dispatcher: RTL

- Drives the control side of a neural layer unit; one instance sits upstream of a layer of `neural` units.
- Accepts one pre-synaptic spike vector per timestep over a valid/ready handshake.
- Serialises the set bits into `spk_addr` with `en_accum` held high, pulses `en_activ`, then captures the layer's `post_syn_spk` and returns it downstream over valid/ready.
- Counts timesteps and flags the end of an inference window.

---
 rtl/spike_dispatcher.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spike_dispatcher.sv
// Control sequencer for one neural layer unit: serialises a timestep's input spikes into
// accumulate events, triggers activation, and returns the captured post-synaptic spikes.
module spike_dispatcher #(
  parameter int unsigned PRE_SYN_LAYER_SIZE = 16,
  parameter int unsigned NEURAL_SIZE        = 4,
  parameter int unsigned EVENT_CYCLES       = 3,
  parameter int unsigned ACTIV_CYCLES       = 10,
  parameter int unsigned NUM_STEPS          = 25
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_spk_valid,
  output logic                                  in_spk_ready,
  input  logic [PRE_SYN_LAYER_SIZE-1:0]         in_spk,
  output logic                                  en_accum,
  output logic                                  en_activ,
  output logic [$clog2(PRE_SYN_LAYER_SIZE)-1:0] spk_addr,
  input  logic [NEURAL_SIZE-1:0]                post_syn_spk,
  output logic                                  out_spk_valid,
  input  logic                                  out_spk_ready,
  output logic [NEURAL_SIZE-1:0]                out_spk,
  output logic [$clog2(NUM_STEPS)-1:0]          step_cnt,
  output logic                                  layer_done
);

  localparam int unsigned W      = PRE_SYN_LAYER_SIZE;
  localparam int unsigned AW     = $clog2(PRE_SYN_LAYER_SIZE);
  localparam int unsigned SW     = $clog2(NUM_STEPS);
  localparam int unsigned EV_LEN = EVENT_CYCLES * NEURAL_SIZE;
  localparam int unsigned CNT_MAX = (EV_LEN > ACTIV_CYCLES) ? EV_LEN : ACTIV_CYCLES;
  localparam int unsigned CW     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    StIdle, StScan, StAccum, StDrain, StActiv, StWaitAct, StOut
  } state_e;

  state_e         state;
  logic [W-1:0]   pend;
  logic [CW-1:0]  ev_cnt;

  function automatic logic [AW-1:0] lowest(input logic [W-1:0] v);
    lowest = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (v[i]) lowest = AW'(i);
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      pend          <= '0;
      ev_cnt        <= '0;
      in_spk_ready  <= 1'b0;
      en_accum      <= 1'b0;
      en_activ      <= 1'b0;
      spk_addr      <= '0;
      out_spk_valid <= 1'b0;
      out_spk       <= '0;
      step_cnt      <= '0;
      layer_done    <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_spk_valid && in_spk_ready) begin
            pend         <= in_spk;
            in_spk_ready <= 1'b0;
            state        <= StScan;
          end else begin
            in_spk_ready <= 1'b1;
          end
        end
        StScan: begin
          if (pend == '0) begin
            en_activ <= 1'b1;
            state    <= StActiv;
          end else begin
            spk_addr <= lowest(pend);
            pend     <= pend & (pend - W'(1));
            ev_cnt   <= '0;
            en_accum <= 1'b1;
            state    <= StAccum;
          end
        end
        StAccum: begin
          if (ev_cnt == CW'(EV_LEN - 1)) begin
            ev_cnt <= '0;
            if (pend != '0) begin
              // Back-to-back spikes keep en_accum high with no bubble.
              spk_addr <= lowest(pend);
              pend     <= pend & (pend - W'(1));
            end else begin
              en_accum <= 1'b0;
              state    <= StDrain;
            end
          end else begin
            ev_cnt <= ev_cnt + CW'(1);
          end
        end
        StDrain: begin
          if (ev_cnt == CW'(EVENT_CYCLES - 1)) begin
            en_activ <= 1'b1;
            state    <= StActiv;
          end else begin
            ev_cnt <= ev_cnt + CW'(1);
          end
        end
        StActiv: begin
          en_activ <= 1'b0;
          ev_cnt   <= '0;
          state    <= StWaitAct;
        end
        StWaitAct: begin
          if (ev_cnt == CW'(ACTIV_CYCLES - 1)) begin
            out_spk       <= post_syn_spk;
            out_spk_valid <= 1'b1;
            state         <= StOut;
          end else begin
            ev_cnt <= ev_cnt + CW'(1);
          end
        end
        StOut: begin
          if (out_spk_ready) begin
            out_spk_valid <= 1'b0;
            if (step_cnt == SW'(NUM_STEPS - 1)) begin
              step_cnt   <= '0;
              layer_done <= 1'b1;
            end else begin
              step_cnt <= step_cnt + SW'(1);
            end
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
